// File: rtl/matmul_pkg.sv
// Shared state encoding and RAM select codes for the matmul job controller.
package matmul_pkg;

   typedef enum logic [2:0] {
      LOAD_X,
      LOAD_Y,
      START,
      WAIT_ACK,
      RUN,
      READ_Z,
      FLUSH
   } state_e;

   localparam logic [1:0] SEL_X = 2'b00;
   localparam logic [1:0] SEL_Y = 2'b01;
   localparam logic [1:0] SEL_Z = 2'b10;

endpackage

// File: rtl/matmul_out_skid.sv
// Two-entry valid/ready buffer for Z read-return data; the head entry drives the
// output so data stays stable while the consumer stalls.
module matmul_out_skid #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  push_last_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_last_o,
   output logic [1:0]            count_o
);

   logic [1:0]            count_q, count_d;
   logic [DATA_WIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
   logic                  head_last_q, head_last_d, tail_last_q, tail_last_d;
   logic                  pop;
   logic [1:0]            slot;

   assign pop = out_valid_o & out_ready_i;

   // A pop shifts the tail forward first, so a same-cycle push lands in the freed slot.
   always_comb begin
      head_data_d = head_data_q;
      head_last_d = head_last_q;
      tail_data_d = tail_data_q;
      tail_last_d = tail_last_q;
      slot        = count_q - {1'b0, pop};
      if (pop && count_q == 2'd2) begin
         head_data_d = tail_data_q;
         head_last_d = tail_last_q;
      end
      if (push_i) begin
         if (slot == 2'd0) begin
            head_data_d = push_data_i;
            head_last_d = push_last_i;
         end else begin
            tail_data_d = push_data_i;
            tail_last_d = push_last_i;
         end
      end
      count_d = slot + {1'b0, push_i};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) count_q <= 2'd0;
      else      count_q <= count_d;
   end

   always_ff @(posedge clk) begin
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
   end

   assign out_valid_o = (count_q != 2'd0);
   assign out_data_o  = head_data_q;
   assign out_last_o  = out_valid_o & head_last_q;
   assign count_o     = count_q;

endmodule

// File: rtl/matmul_job_controller.sv
// Streaming job sequencer for the matmul top: loads X/Y, launches, reads Z back out.
// Optional MATMUL_CTRL_PERF_EN adds a saturating compute-cycle counter on perf_cycles.
module matmul_job_controller
   import matmul_pkg::*;
#(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int X_ROWS        = 5,
   parameter int Y_COLS        = 5,
   parameter int X_COLS_Y_ROWS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  done,
   output logic [31:0]           perf_cycles,
   output logic                  mm_start,
   input  logic                  mm_busy,
   output logic [ADDR_WIDTH-1:0] mm_ram_addr,
   output logic                  mm_ram_wen,
   output logic [1:0]            mm_ram_sel,
   output logic [DATA_WIDTH-1:0] mm_ram_data_in,
   input  logic [DATA_WIDTH-1:0] mm_ram_data_out
);

   localparam logic [ADDR_WIDTH-1:0] NX = ADDR_WIDTH'(X_ROWS * X_COLS_Y_ROWS);
   localparam logic [ADDR_WIDTH-1:0] NY = ADDR_WIDTH'(X_COLS_Y_ROWS * Y_COLS);
   localparam logic [ADDR_WIDTH-1:0] NZ = ADDR_WIDTH'(X_ROWS * Y_COLS);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  rd_pend_q, rd_last_q, done_q;
   logic                  in_hs, out_hs, rd_issue;
   logic [1:0]            skid_count;
   logic [2:0]            occ;

   assign in_hs  = in_valid & in_ready;
   assign out_hs = out_valid & out_ready;

   // Credit counts entries that will remain after this cycle's pop plus the read in flight.
   assign occ      = {1'b0, skid_count} + {2'b00, rd_pend_q} - {2'b00, out_hs};
   assign rd_issue = (state_q == READ_Z) && (occ < 3'd2);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= LOAD_X;
         cnt_q     <= '0;
         rd_pend_q <= 1'b0;
         rd_last_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_pend_q <= rd_issue;
         rd_last_q <= rd_issue && (cnt_q == NZ - 1'b1);
         done_q    <= out_hs & out_last;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         LOAD_X: if (in_hs) begin
            if (cnt_q == NX - 1'b1) begin
               state_d = LOAD_Y;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
         end
         LOAD_Y: if (in_hs) begin
            if (cnt_q == NY - 1'b1) begin
               state_d = START;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
         end
         START:    state_d = WAIT_ACK;
         WAIT_ACK: if (mm_busy)  state_d = RUN;
         RUN:      if (!mm_busy) state_d = READ_Z;
         READ_Z: if (rd_issue) begin
            if (cnt_q == NZ - 1'b1) begin
               state_d = FLUSH;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
         end
         FLUSH: if (out_hs && out_last) begin
            state_d = LOAD_X;
            cnt_d   = '0;
         end
         default: state_d = LOAD_X;
      endcase
   end

   always_comb begin
      in_ready   = rst & ((state_q == LOAD_X) || (state_q == LOAD_Y));
      mm_start   = (state_q == START);
      mm_ram_wen = in_valid & in_ready;
      mm_ram_sel = SEL_X;
      if (state_q == LOAD_Y) mm_ram_sel = SEL_Y;
      else if ((state_q == READ_Z) || (state_q == FLUSH)) mm_ram_sel = SEL_Z;
   end

   assign mm_ram_addr    = cnt_q;
   assign mm_ram_data_in = in_data;
   assign done           = done_q;

   matmul_out_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .push_i      (rd_pend_q),
      .push_data_i (mm_ram_data_out),
      .push_last_i (rd_last_q),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_last_o  (out_last),
      .count_o     (skid_count)
   );

`ifdef MATMUL_CTRL_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (state_q == START) perf_d = '0;
      else if (((state_q == WAIT_ACK) || (state_q == RUN)) && (perf_q != '1))
         perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) perf_q <= '0;
      else      perf_q <= perf_d;
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_matmul_job_controller.sv
// Bench for matmul_job_controller: a 2x2x2 and a 5x5x5 instance, each with a RAM/multiplier model.
module tb_matmul_job_controller;

   typedef struct packed {
      logic        inst;
      logic [31:0] data;
      logic        last;
   } exp_t;

`ifdef MATMUL_CTRL_PERF_EN
   localparam logic [31:0] PERF_EXP = 32'd38;
`else
   localparam logic [31:0] PERF_EXP = 32'd0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [1:0]       in_valid, in_ready, out_valid, out_ready, out_last, done, mm_start, mm_ram_wen;
   logic [1:0][31:0] in_data, out_data, perf_cycles, mm_ram_addr, mm_ram_data_in;
   logic [1:0][1:0]  mm_ram_sel;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   int   busy_len = 37;
   int   rdy_mode = 0;
   int   acc_cnt[2]   = '{0, 0};
   int   start_cnt[2] = '{0, 0};
   logic [1:0]       pend_done = '0;
   logic [1:0]       held_v    = '0;
   logic [1:0][31:0] held_d    = '0;
   logic [31:0] xv[25], yv[25], zv[25];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int R = (g == 0) ? 2 : 5;
      logic        busy;
      int          rem;
      logic [31:0] rdata, acc;
      logic [31:0] xm[25], ym[25], zm[25];

      matmul_job_controller #(
         .ADDR_WIDTH(32), .DATA_WIDTH(32), .X_ROWS(R), .Y_COLS(R), .X_COLS_Y_ROWS(R)
      ) dut (
         .clk(clk), .rst(rst),
         .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
         .out_last(out_last[g]), .done(done[g]), .perf_cycles(perf_cycles[g]),
         .mm_start(mm_start[g]), .mm_busy(busy),
         .mm_ram_addr(mm_ram_addr[g]), .mm_ram_wen(mm_ram_wen[g]), .mm_ram_sel(mm_ram_sel[g]),
         .mm_ram_data_in(mm_ram_data_in[g]), .mm_ram_data_out(rdata)
      );

      always @(posedge clk) begin
         if (mm_ram_wen[g] && mm_ram_addr[g] < 32'd25) begin
            if (mm_ram_sel[g] == 2'b00) xm[mm_ram_addr[g]] <= mm_ram_data_in[g];
            else if (mm_ram_sel[g] == 2'b01) ym[mm_ram_addr[g]] <= mm_ram_data_in[g];
         end
         rdata <= (mm_ram_sel[g] == 2'b10 && mm_ram_addr[g] < 32'd25) ? zm[mm_ram_addr[g]] : 32'h0;
      end

      always @(posedge clk or negedge rst) begin
         if (!rst) begin
            busy <= 1'b0;
            rem  <= 0;
         end else if (mm_start[g]) begin
            busy <= 1'b1;
            rem  <= busy_len;
            for (int i = 0; i < R; i++)
               for (int j = 0; j < R; j++) begin
                  acc = 32'h0;
                  for (int k = 0; k < R; k++) acc = acc + xm[i*R+k] * ym[k*R+j];
                  zm[i*R+j] <= acc;
               end
         end else if (busy) begin
            rem <= rem - 1;
            if (rem == 1) busy <= 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Scoreboard monitor: pops on every output handshake, also tracks done and stall stability.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (!rst) begin
            pend_done[g] <= 1'b0;
            held_v[g]    <= 1'b0;
         end else begin
            if (pend_done[g] || done[g]) chk("done_pulse", 32'(done[g]), 32'(pend_done[g]));
            if (held_v[g]) begin
               chk("stall_valid", 32'(out_valid[g]), 32'd1);
               chk("stall_data", out_data[g], held_d[g]);
            end
            if (in_valid[g] && in_ready[g]) acc_cnt[g] <= acc_cnt[g] + 1;
            if (mm_start[g]) start_cnt[g] <= start_cnt[g] + 1;
            if (out_valid[g] && out_ready[g]) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL z_unexpected: got %0d expected no output", out_data[g]);
               end else begin
                  chk("z_inst", 32'(g), 32'(exp_q[0].inst));
                  chk("z_data", out_data[g], exp_q[0].data);
                  chk("z_last", 32'(out_last[g]), 32'(exp_q[0].last));
                  void'(exp_q.pop_front());
               end
            end
            pend_done[g] <= out_valid[g] & out_ready[g] & out_last[g];
            held_v[g]    <= out_valid[g] & ~out_ready[g];
            held_d[g]    <= out_data[g];
         end
      end
   end

   initial begin
      int rc;
      bit r;
      rc = 0;
      out_ready = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) begin
            rc = 0;
            out_ready = 2'b11;
         end else begin
            rc++;
            if (rc <= 4) r = (rc == 1 || rc == 4);
            else r = 1'($urandom_range(0, 1));
            out_ready = {r, r};
         end
      end
   end

   task automatic check_reset(input int g);
      chk("rst_in_ready", 32'(in_ready[g]), 32'd0);
      chk("rst_out_valid", 32'(out_valid[g]), 32'd0);
      chk("rst_out_last", 32'(out_last[g]), 32'd0);
      chk("rst_done", 32'(done[g]), 32'd0);
      chk("rst_mm_start", 32'(mm_start[g]), 32'd0);
      chk("rst_wen", 32'(mm_ram_wen[g]), 32'd0);
      chk("rst_sel", 32'(mm_ram_sel[g]), 32'd0);
      chk("rst_addr", mm_ram_addr[g], 32'd0);
      chk("rst_perf", perf_cycles[g], 32'd0);
   endtask

   task automatic run_job(input int g, input int nx, input int ny, input int nz,
                          input bit hold, input bit abort);
      exp_t e;
      int   base_acc, base_start, viol;
      bit   seen;
      if (!abort)
         for (int i = 0; i < nz; i++) begin
            e.inst = g[0];
            e.data = zv[i];
            e.last = (i == nz - 1);
            exp_q.push_back(e);
         end
      base_acc   = acc_cnt[g];
      base_start = start_cnt[g];
      for (int n = 0; n < nx + ny; n++) begin
         in_valid[g] = 1'b1;
         in_data[g]  = (n < nx) ? xv[n] : yv[n-nx];
         @(posedge clk);
         #1;
      end
      chk("start_latency", 32'(mm_start[g]), 32'd1);
      if (hold) in_data[g] = 32'hDEAD_BEEF;
      else in_valid[g] = 1'b0;
      if (abort) return;
      viol = in_ready[g] ? 1 : 0;
      seen = 1'b0;
      for (int t = 0; t < 3000 && !seen; t++) begin
         @(posedge clk);
         #3;
         if (done[g]) seen = 1'b1;
         else begin
            if (in_ready[g]) viol++;
            if (hold && out_valid[g] && out_ready[g] && out_last[g]) in_valid[g] = 1'b0;
         end
      end
      in_valid[g] = 1'b0;
      chk("done_seen", 32'(seen), 32'd1);
      chk("beats_accepted", 32'(acc_cnt[g] - base_acc), 32'(nx + ny));
      chk("start_pulses", 32'(start_cnt[g] - base_start), 32'd1);
      if (hold) chk("in_ready_low", 32'(viol), 32'd0);
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = '0;
      in_data  = '0;
      repeat (2) @(negedge clk);
      check_reset(0);
      check_reset(1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("in_ready_after_rst", 32'(in_ready[0]), 32'd1);
      @(posedge clk);
      #1;

      xv[0] = 1;  xv[1] = 2;  xv[2] = 3;  xv[3] = 4;
      yv[0] = 5;  yv[1] = 6;  yv[2] = 7;  yv[3] = 8;
      zv[0] = 19; zv[1] = 22; zv[2] = 43; zv[3] = 50;
      busy_len = 37;
      run_job(0, 4, 4, 4, 1'b0, 1'b0);
      chk("perf_cycles", perf_cycles[0], PERF_EXP);

      busy_len = 3;
      rdy_mode = 1;
      run_job(0, 4, 4, 4, 1'b0, 1'b0);
      rdy_mode = 0;

      run_job(0, 4, 4, 4, 1'b1, 1'b0);

      busy_len = 20;
      run_job(0, 4, 4, 4, 1'b0, 1'b1);
      repeat (6) @(posedge clk);
      #3;
      chk("run_in_ready", 32'(in_ready[0]), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_reset(0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      xv[0] = 2;  xv[1] = 0;  xv[2] = 1;  xv[3] = 3;
      yv[0] = 1;  yv[1] = 4;  yv[2] = 2;  yv[3] = 5;
      zv[0] = 2;  zv[1] = 8;  zv[2] = 7;  zv[3] = 19;
      busy_len = 4;
      run_job(0, 4, 4, 4, 1'b0, 1'b0);

      for (int i = 0; i < 25; i++) begin
         xv[i] = 32'(i * 7 + 3);
         yv[i] = (i / 5 == i % 5) ? 32'd1 : 32'd0;
         zv[i] = xv[i];
      end
      busy_len = 5;
      run_job(1, 25, 25, 25, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matmul_job_controller.md
# matmul_job_controller

Sequencer that owns the host-side RAM port and start/busy handshake of the matrix-multiply top. Accepts a single valid/ready input stream carrying all X elements then all Y elements, writes them into the X and Y RAMs, launches the multiplier, waits for completion, then streams the Z result out on a valid/ready output with a last marker. It turns the multiply datapath into a streaming accelerator for the rest of the design.

## Interface
- ADDR_WIDTH, 32, RAM address width
- DATA_WIDTH, 32, element width
- X_ROWS, 5, rows of X and Z
- Y_COLS, 5, columns of Y and Z
- X_COLS_Y_ROWS, 5, inner dimension
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid / in_ready / in_data  in/out/in  1/1/DATA_WIDTH  load stream: X row-major, then Y row-major
- out_valid / out_ready / out_data / out_last  out/in/out/out  1/1/DATA_WIDTH/1  Z stream, row-major
- done  out  1  one-cycle pulse after final Z handshake
- perf_cycles  out  32  compute cycle count of last job
- mm_start  out  1  to top start
- mm_busy  in  1  from top busy
- mm_ram_addr / mm_ram_wen / mm_ram_sel / mm_ram_data_in  out  ADDR_WIDTH/1/2/DATA_WIDTH  to top RAM port
- mm_ram_data_out  in  DATA_WIDTH  from top; valid one cycle after address (registered read)

## Operation
- Counts: NX = X_ROWS*X_COLS_Y_ROWS, NY = X_COLS_Y_ROWS*Y_COLS, NZ = X_ROWS*Y_COLS; computed as ADDR_WIDTH constants.
- States: LOAD_X, LOAD_Y, START, WAIT_ACK, RUN, READ_Z, FLUSH.
- LOAD_X: in_ready=1, sel=2'b00, addr=element counter, wen=in_valid&in_ready, data_in=in_data (combinational). After NX-th beat -> LOAD_Y, counter clears.
- LOAD_Y: same with sel=2'b01; after NY-th beat -> START.
- START: mm_start=1 for exactly one cycle -> WAIT_ACK.
- WAIT_ACK: wait mm_busy=1 -> RUN. RUN: wait mm_busy=0 -> READ_Z.
- READ_Z: sel=2'b10, wen=0; issue read of addr k when skid credit available (entries + in-flight < 2); read data enters skid one cycle later. After NZ issues -> FLUSH.
- FLUSH: drain skid; out_last=1 on element NZ-1; on its handshake assert done, return to LOAD_X, counters clear.
- in_ready=0 in every state except LOAD_X/LOAD_Y; mm_ram_wen=0 outside them.
- out_data holds stable while out_valid & ~out_ready.
- Element counters are ADDR_WIDTH bits; no wrap within a job (NX, NY, NZ < 2^ADDR_WIDTH required).

## Timing
- Reset: state LOAD_X, all counters 0, in_ready=0 during reset then 1, out_valid=0, out_last=0, done=0, mm_start=0, mm_ram_wen=0, mm_ram_sel=2'b00, mm_ram_addr=0, perf_cycles=0.
- Load: one element per cycle at full rate; zero added latency.
- Last Y beat to mm_start: 1 cycle.
- busy falling edge to first Z read issue: 1 cycle; first out_valid 1 cycle later.
- Readout sustains 1 element/cycle with out_ready held high; with out_ready low no element lost or duplicated.
- Reset asserted mid-job: immediate return to reset values; partial RAM contents are not cleared; next job overwrites.
- mm_busy high in LOAD states is ignored.

## Configuration
- MATMUL_CTRL_PERF_EN defined: 32-bit counter clears on mm_start, increments each cycle in WAIT_ACK and RUN, saturates at all-ones; perf_cycles holds value until next mm_start.
- Undefined: counter absent, perf_cycles tied to 0.

## Structure
- Package matmul_pkg: state enum typedef, RAM select constants (SEL_X=2'b00, SEL_Y=2'b01, SEL_Z=2'b10).
- Sub-module matmul_out_skid: 2-entry valid/ready buffer holding read-return data and last flag; exposes entry count for credit logic.

## Test plan
- 2x2x2 job, X=1,2,3,4, Y=5,6,7,8, behavioural multiplier model -> out 19,22,43,50, out_last on 50, done one cycle after.
- Same job, out_ready toggled 1-0-0-1 random -> identical stream, no drops/duplicates, data stable while stalled.
- in_valid held high through compute -> exactly NX+NY beats accepted; in_ready=0 from START until done.
- rst low during RUN -> all outputs at reset values next edge; fresh job afterwards produces correct Z.
- Macro defined, model busy for 37 cycles -> perf_cycles=37 (+ack cycle per model), 0 when undefined.
- Default 5x5x5 job with identity Y -> Z equals X.
